// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bus bundle between the two RAM requesters (CPU, debug),
// the ram_arbiter and the data RAM.
//   cpu_*/dbg_* : req, we, addr, wdata from requester; gnt, rvalid, rdata back
//   dbg_lock    : debug port keeps RAM ownership while asserted
//   mem_*       : RAM write enable, shared address, write data, read data
//   busy        : lock FSM is in LOCKED
// modport master : requester/RAM environment side
// modport slave  : arbiter side
interface ram_arbiter_if #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 16
);
    logic                 cpu_req;
    logic                 cpu_we;
    logic [AddrWidth-1:0] cpu_addr;
    logic [DataWidth-1:0] cpu_wdata;
    logic                 cpu_gnt;
    logic                 cpu_rvalid;
    logic [DataWidth-1:0] cpu_rdata;

    logic                 dbg_req;
    logic                 dbg_we;
    logic [AddrWidth-1:0] dbg_addr;
    logic [DataWidth-1:0] dbg_wdata;
    logic                 dbg_gnt;
    logic                 dbg_rvalid;
    logic [DataWidth-1:0] dbg_rdata;
    logic                 dbg_lock;

    logic                 mem_we;
    logic [AddrWidth-1:0] mem_addr;
    logic [DataWidth-1:0] mem_wdata;
    logic [DataWidth-1:0] mem_rdata;

    logic                 busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one data RAM between the CPU load/store path and the
// debug/loader port. At most one request is granted per cycle (grant is
// combinational), the granted access is driven straight onto the RAM bus, and
// load data comes back one cycle later with an rvalid strobe to the requester
// that issued it. The debug port can lock the RAM across a burst.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : ram_arbiter_if.slave (requester handshakes, dbg_lock, RAM bus, busy)
// Configuration macro:
//   RAM_ARB_FAIR_EN defined -> round-robin tie-break (loser of last grant wins)
//   undefined               -> fixed priority, CPU wins ties
module ram_arbiter #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 16
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam logic       LAST_CPU  = 1'b0;
    localparam logic       LAST_DBG  = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic                 r_last_gnt;
    logic                 r_cpu_pend;
    logic                 r_dbg_pend;
    logic [AddrWidth-1:0] r_mem_addr;
    logic [DataWidth-1:0] r_mem_wdata;

    logic                 w_cpu_gnt;
    logic                 w_dbg_gnt;
    logic                 w_tie_dbg;
    logic                 w_mem_we;
    logic [AddrWidth-1:0] w_mem_addr;
    logic [DataWidth-1:0] w_mem_wdata;

`ifdef RAM_ARB_FAIR_EN
    // Round-robin: on a tie the requester that did not get the last grant wins.
    assign w_tie_dbg = (r_last_gnt == LAST_CPU);
`else
    // Fixed priority: the CPU always wins a tie.
    assign w_tie_dbg = 1'b0;
`endif

    // Grant decision; grants are suppressed while reset is asserted.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dbg_gnt = 1'b0;
        if (rst) begin
            w_cpu_gnt = 1'b0;
            w_dbg_gnt = 1'b0;
        end else begin
            case (r_state)
                ST_LOCKED: begin
                    w_cpu_gnt = 1'b0;
                    w_dbg_gnt = bus.dbg_req;
                end
                ST_IDLE: begin
                    if (bus.cpu_req && bus.dbg_req) begin
                        w_cpu_gnt = ~w_tie_dbg;
                        w_dbg_gnt = w_tie_dbg;
                    end else begin
                        w_cpu_gnt = bus.cpu_req;
                        w_dbg_gnt = bus.dbg_req;
                    end
                end
                default: begin
                    w_cpu_gnt = 1'b0;
                    w_dbg_gnt = 1'b0;
                end
            endcase
        end
    end

    // RAM bus mux; without a grant the address/data hold the last granted value.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        if (w_cpu_gnt) begin
            w_mem_we    = bus.cpu_we;
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
        end else if (w_dbg_gnt) begin
            w_mem_we    = bus.dbg_we;
            w_mem_addr  = bus.dbg_addr;
            w_mem_wdata = bus.dbg_wdata;
        end else begin
            w_mem_we    = 1'b0;
            w_mem_addr  = r_mem_addr;
            w_mem_wdata = r_mem_wdata;
        end
    end

    // Lock FSM next state; the unlock cycle itself still behaves as LOCKED.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_dbg_gnt && bus.dbg_lock) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (!bus.dbg_lock) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, last-grant, pending-read and RAM bus hold registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_gnt  <= LAST_DBG;
            r_cpu_pend  <= 1'b0;
            r_dbg_pend  <= 1'b0;
            r_mem_addr  <= {AddrWidth{1'b0}};
            r_mem_wdata <= {DataWidth{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_cpu_pend <= w_cpu_gnt & ~bus.cpu_we;
            r_dbg_pend <= w_dbg_gnt & ~bus.dbg_we;
            if (w_cpu_gnt || w_dbg_gnt) begin
                r_last_gnt  <= w_dbg_gnt ? LAST_DBG : LAST_CPU;
                r_mem_addr  <= w_mem_addr;
                r_mem_wdata <= w_mem_wdata;
            end else begin
                r_last_gnt  <= r_last_gnt;
                r_mem_addr  <= r_mem_addr;
                r_mem_wdata <= r_mem_wdata;
            end
        end
    end

    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.dbg_gnt    = w_dbg_gnt;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.cpu_rvalid = r_cpu_pend;
    assign bus.dbg_rvalid = r_dbg_pend;
    // Read data is steered only to the requester whose load is returning.
    assign bus.cpu_rdata  = r_cpu_pend ? bus.mem_rdata : {DataWidth{1'b0}};
    assign bus.dbg_rdata  = r_dbg_pend ? bus.mem_rdata : {DataWidth{1'b0}};
    assign bus.busy       = (r_state == ST_LOCKED);
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter. Contains a behavioural
// RAM (1-cycle registered read) and a reference model of arbitration, lock,
// bus hold and read return, checked every cycle plus directed scenarios.
module tb_ram_arbiter;
    localparam int DW = 16;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter_if #(.DataWidth(DW), .AddrWidth(AW)) bus();
    ram_arbiter #(.DataWidth(DW), .AddrWidth(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] ram [0:65535];
    logic [DW-1:0] mm  [0:65535];

    // RAM: read-before-write, registered read data.
    always @(posedge clk) begin
        bus.mem_rdata <= ram[bus.mem_addr];
        if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
    end

    int checks = 0;
    int failures = 0;

    bit m_locked, m_last_dbg, m_pend_c, m_pend_d;
    logic [DW-1:0] m_pdata;
    logic [AW-1:0] m_addr_hold;
    bit o_cg, o_dg, o_busy;

    task automatic model_reset();
        m_locked = 1'b0; m_last_dbg = 1'b1; m_pend_c = 1'b0; m_pend_d = 1'b0;
        m_addr_hold = 16'h0000; m_pdata = 16'h0000;
    endtask

    task automatic drive_idle();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 16'h0000;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0000; bus.dbg_wdata = 16'h0000;
        bus.dbg_lock = 1'b0;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus, compared against the reference model.
    task automatic run_cycle(input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                             input logic [DW-1:0] cwd, input bit dreq, input bit dwe,
                             input logic [AW-1:0] daddr, input logic [DW-1:0] dwd, input bit lock);
        bit e_cg, e_dg, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
        bus.dbg_req = dreq; bus.dbg_we = dwe; bus.dbg_addr = daddr; bus.dbg_wdata = dwd;
        bus.dbg_lock = lock;
        #2;
        if (m_locked) begin
            e_cg = 1'b0; e_dg = dreq;
        end else if (creq && dreq) begin
`ifdef RAM_ARB_FAIR_EN
            e_dg = !m_last_dbg;
`else
            e_dg = 1'b0;
`endif
            e_cg = !e_dg;
        end else begin
            e_cg = creq; e_dg = dreq;
        end
        e_we = e_cg ? cwe : (e_dg ? dwe : 1'b0);
        e_addr = e_cg ? caddr : (e_dg ? daddr : m_addr_hold);
        e_wd = e_cg ? cwd : dwd;
        checks++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.mem_we, bus.busy} !== {e_cg, e_dg, e_we, m_locked}) begin
            failures++;
            $display("FAIL ctrl{cg,dg,we,busy} t=%0t got=%b exp=%b", $time,
                     {bus.cpu_gnt, bus.dbg_gnt, bus.mem_we, bus.busy}, {e_cg, e_dg, e_we, m_locked});
        end
        checks++;
        if (bus.mem_addr !== e_addr) begin
            failures++;
            $display("FAIL mem_addr t=%0t got=%h exp=%h", $time, bus.mem_addr, e_addr);
        end
        if (e_we) begin
            checks++;
            if (bus.mem_wdata !== e_wd) begin
                failures++;
                $display("FAIL mem_wdata t=%0t got=%h exp=%h", $time, bus.mem_wdata, e_wd);
            end
        end
        checks++;
        if ({bus.cpu_rvalid, bus.dbg_rvalid} !== {m_pend_c, m_pend_d}) begin
            failures++;
            $display("FAIL rvalid{c,d} t=%0t got=%b exp=%b", $time,
                     {bus.cpu_rvalid, bus.dbg_rvalid}, {m_pend_c, m_pend_d});
        end
        if (m_pend_c || m_pend_d) begin
            checks++;
            if ((m_pend_c ? bus.cpu_rdata : bus.dbg_rdata) !== m_pdata) begin
                failures++;
                $display("FAIL rdata t=%0t got=%h exp=%h", $time,
                         m_pend_c ? bus.cpu_rdata : bus.dbg_rdata, m_pdata);
            end
        end
        o_cg = bus.cpu_gnt; o_dg = bus.dbg_gnt; o_busy = bus.busy;
        @(posedge clk); #1;
        m_pend_c = e_cg && !cwe;
        m_pend_d = e_dg && !dwe;
        if ((e_cg || e_dg) && !e_we) m_pdata = mm[e_addr];
        if (e_we) mm[e_addr] = e_wd;
        if (e_cg || e_dg) begin
            m_addr_hold = e_addr;
            m_last_dbg = e_dg;
        end
        if (!m_locked) m_locked = e_dg && lock;
        else m_locked = lock;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.cpu_req = 1'b1; bus.dbg_req = 1'b1;
        rst = 1'b1;
        #2;
        checks++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.mem_we, bus.busy} !== 6'b000000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid, bus.mem_we, bus.busy});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dbg_rdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_bus got=%h exp=0", {bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dbg_rdata});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();
        model_reset();
    endtask

    task automatic test_load();
        run_cycle(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checks++;
        if (o_cg !== 1'b1) begin
            failures++;
            $display("FAIL load_gnt got=%b exp=1", o_cg);
        end
        checks++;
        if ({bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata} !== {1'b1, 1'b0, 16'h1234}) begin
            failures++;
            $display("FAIL load_data got=%b/%b/%h exp=1/0/1234", bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata);
        end
        run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_store_then_load();
        run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0005, 16'hBEEF, 1'b0);
        run_cycle(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checks++;
        if ({bus.dbg_rvalid, bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 1'b1, 16'hBEEF}) begin
            failures++;
            $display("FAIL store_load got=%b/%b/%h exp=0/1/beef", bus.dbg_rvalid, bus.cpu_rvalid, bus.cpu_rdata);
        end
        run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_tie();
        logic [11:0] seq;
        logic [11:0] exp_seq;
        apply_reset();
        seq = 12'h000;
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b1, 1'b0, 16'(16'h0010 + i), 16'h0000, 1'b1, 1'b0, 16'(16'h0020 + i), 16'h0000, 1'b0);
            seq = {seq[9:0], o_cg, o_dg};
        end
`ifdef RAM_ARB_FAIR_EN
        exp_seq = 12'b10_01_10_01_10_01;
`else
        exp_seq = 12'b10_10_10_10_10_10;
`endif
        checks++;
        if (seq !== exp_seq) begin
            failures++;
            $display("FAIL tie_seq got=%b exp=%b", seq, exp_seq);
        end
        run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_lock();
        run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b1, 16'(16'h0031 + i), 16'(16'hA000 + i), 1'b1);
            checks++;
            if ({o_cg, o_dg, o_busy} !== 3'b011) begin
                failures++;
                $display("FAIL lock_hold i=%0d got=%b exp=011", i, {o_cg, o_dg, o_busy});
            end
        end
        run_cycle(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h0035, 16'h0000, 1'b0);
        checks++;
        if ({o_cg, o_dg} !== 2'b01) begin
            failures++;
            $display("FAIL unlock_cycle got=%b exp=01", {o_cg, o_dg});
        end
        run_cycle(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checks++;
        if ({o_cg, o_busy} !== 2'b10) begin
            failures++;
            $display("FAIL after_unlock got=%b exp=10", {o_cg, o_busy});
        end
        run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_cycle(1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        drive_idle();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata, bus.mem_we, bus.busy, bus.mem_addr} !== 36'h0) begin
            failures++;
            $display("FAIL reset_mid got=%b/%b/%h/%b/%b/%h exp=all zero", bus.cpu_rvalid, bus.dbg_rvalid,
                     bus.cpu_rdata, bus.mem_we, bus.busy, bus.mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_idle_hold();
        run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h00AB, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            checks++;
            if ({bus.mem_we, bus.mem_addr} !== {1'b0, 16'h00AB}) begin
                failures++;
                $display("FAIL idle_hold i=%0d got=%b/%h exp=0/00ab", i, bus.mem_we, bus.mem_addr);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)),
                      16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      16'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        run_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 16'(i * 7) ^ 16'h5A5A;
            mm[i]  = 16'(i * 7) ^ 16'h5A5A;
        end
        ram[3] = 16'h1234;
        mm[3]  = 16'h1234;
        drive_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_load();
        test_store_then_load();
        test_tie();
        test_lock();
        test_reset_mid();
        test_idle_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
